// File: rtl/checker_line_arbiter.sv
// Two-source line arbiter in front of a single character-format checker.
// Grants one whole line per source (round-robin), sequences checker reset and reports results.
module checker_line_arbiter #(
  parameter int MAX_LINE = 64,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s0_char,
  input  logic             s0_valid,
  output logic             s0_ready,
  input  logic [7:0]       s1_char,
  input  logic             s1_valid,
  output logic             s1_ready,
  output logic [7:0]       chk_char,
  output logic             chk_reset,
  input  logic [1:0]       chk_format,
  output logic             res_valid,
  output logic             res_src,
  output logic [1:0]       res_type,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_reg,
  output logic [CNT_W-1:0] cnt_mem,
  output logic [CNT_W-1:0] cnt_bad,
  output logic [CNT_W-1:0] cnt_abort
);

  localparam int               LEN_W   = $clog2(MAX_LINE + 1);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LINE);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [7:0]       EOL     = 8'h23;
  localparam logic [7:0]       FILLER  = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    WAIT1,
    WAIT2,
    FLUSH
  } state_t;

  state_t           state;
  logic             gsel;
  logic             last;
  logic [LEN_W-1:0] len;

  logic [7:0]       cur_char;
  logic             cur_valid;
  logic             cur_ready;
  logic             hs;
  logic             pick;
  logic [LEN_W-1:0] len_nx;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  assign cur_char  = gsel ? s1_char  : s0_char;
  assign cur_valid = gsel ? s1_valid : s0_valid;
  assign cur_ready = gsel ? s1_ready : s0_ready;
  assign hs        = cur_valid && cur_ready;
  assign len_nx    = len + LEN_ONE;
  // On a tie the source that did not finish the previous line wins.
  assign pick      = (s0_valid && s1_valid) ? ~last : s1_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      gsel      <= 1'b0;
      last      <= 1'b1;
      len       <= '0;
      s0_ready  <= 1'b0;
      s1_ready  <= 1'b0;
      chk_char  <= FILLER;
      chk_reset <= 1'b1;
      res_valid <= 1'b0;
      res_src   <= 1'b0;
      res_type  <= 2'b00;
      busy      <= 1'b0;
      cnt_reg   <= '0;
      cnt_mem   <= '0;
      cnt_bad   <= '0;
      cnt_abort <= '0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        IDLE: begin
          chk_reset <= 1'b0;
          chk_char  <= FILLER;
          if (s0_valid || s1_valid) begin
            gsel     <= pick;
            s0_ready <= ~pick;
            s1_ready <= pick;
            len      <= '0;
            busy     <= 1'b1;
            state    <= GRANT;
          end
        end
        GRANT: begin
          if (hs) begin
            chk_char <= cur_char;
            len      <= len_nx;
            if (cur_char == EOL) begin
              s0_ready <= 1'b0;
              s1_ready <= 1'b0;
              state    <= WAIT1;
            end else if (len_nx == LEN_MAX) begin
              s0_ready <= 1'b0;
              s1_ready <= 1'b0;
              state    <= FLUSH;
            end
          end else begin
            chk_char <= FILLER;
            // A stalled source mid-line is treated as a broken line.
            if (len != '0) begin
              s0_ready <= 1'b0;
              s1_ready <= 1'b0;
              state    <= FLUSH;
            end
          end
        end
        WAIT1: begin
          chk_char <= FILLER;
          state    <= WAIT2;
        end
        WAIT2: begin
          res_type  <= chk_format;
          res_src   <= gsel;
          res_valid <= 1'b1;
          case (chk_format)
            2'b01:   cnt_reg <= sat_inc(cnt_reg);
            2'b10:   cnt_mem <= sat_inc(cnt_mem);
            default: cnt_bad <= sat_inc(cnt_bad);
          endcase
          last  <= gsel;
          busy  <= 1'b0;
          state <= IDLE;
        end
        FLUSH: begin
          chk_reset <= 1'b1;
          chk_char  <= FILLER;
          res_type  <= 2'b11;
          res_src   <= gsel;
          res_valid <= 1'b1;
          cnt_abort <= sat_inc(cnt_abort);
          last      <= gsel;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_checker_line_arbiter.sv
// Directed bench for checker_line_arbiter; a small stand-in checker classifies lines
// ('*' -> mem, 'g' -> bad, otherwise reg) so results depend on correct timing.
module tb_checker_line_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  s0_char = 8'h00;
  logic        s0_valid = 1'b0;
  logic        s0_ready;
  logic [7:0]  s1_char = 8'h00;
  logic        s1_valid = 1'b0;
  logic        s1_ready;
  logic [7:0]  chk_char;
  logic        chk_reset;
  logic [1:0]  chk_format;
  logic        res_valid;
  logic        res_src;
  logic [1:0]  res_type;
  logic        busy;
  logic [15:0] cnt_reg, cnt_mem, cnt_bad, cnt_abort;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  checker_line_arbiter #(.MAX_LINE(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .s0_char(s0_char), .s0_valid(s0_valid), .s0_ready(s0_ready),
    .s1_char(s1_char), .s1_valid(s1_valid), .s1_ready(s1_ready),
    .chk_char(chk_char), .chk_reset(chk_reset), .chk_format(chk_format),
    .res_valid(res_valid), .res_src(res_src), .res_type(res_type), .busy(busy),
    .cnt_reg(cnt_reg), .cnt_mem(cnt_mem), .cnt_bad(cnt_bad), .cnt_abort(cnt_abort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in checker: its format becomes valid one edge after it consumes '#'.
  logic [1:0] fmt = 2'b00;
  logic seen_star = 1'b0;
  logic seen_bad = 1'b0;
  always @(posedge clk) begin
    if (chk_reset) begin
      fmt <= 2'b00; seen_star <= 1'b0; seen_bad <= 1'b0;
    end else if (chk_char == 8'h23) begin
      fmt <= seen_bad ? 2'b00 : (seen_star ? 2'b10 : 2'b01);
      seen_star <= 1'b0; seen_bad <= 1'b0;
    end else if (chk_char == 8'h2a) seen_star <= 1'b1;
    else if (chk_char == 8'h67) seen_bad <= 1'b1;
  end
  assign chk_format = fmt;

  int   res_n = 0, res_cyc = 0, rst_hi = 0, fwd_n = 0, s1_rdy_n = 0;
  logic prev_src = 1'b0, cur_src = 1'b0;
  int   hash0 = 0, hash1 = 0;
  always @(negedge clk) begin
    if (res_valid) begin
      res_n <= res_n + 1; prev_src <= cur_src; cur_src <= res_src; res_cyc <= cyc;
    end
    if (chk_reset) rst_hi <= rst_hi + 1;
    if (chk_char != 8'h00) fwd_n <= fwd_n + 1;
    if (s1_ready) s1_rdy_n <= s1_rdy_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_line(input int src, input string s);
    int   n;
    logic rdy;
    for (int i = 0; i < s.len(); i++) begin
      if (src == 0) begin s0_valid = 1'b1; s0_char = s[i]; end
      else          begin s1_valid = 1'b1; s1_char = s[i]; end
      n = 0; rdy = 1'b0;
      while (!rdy && n < 300) begin
        rdy = (src == 0) ? s0_ready : s1_ready;
        @(posedge clk); #1;
        n++;
      end
      if (!rdy) begin
        check($sformatf("hs_timeout_s%0d", src), 32'(rdy), 1);
        break;
      end
      if (s[i] == 8'h23) begin
        if (src == 0) hash0 = cyc; else hash1 = cyc;
      end
    end
    if (src == 0) begin s0_valid = 1'b0; s0_char = 8'h00; end
    else          begin s1_valid = 1'b0; s1_char = 8'h00; end
  endtask

  task automatic wait_res(input int base, input int need);
    int n = 0;
    while (res_n < base + need && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("res_seen", (res_n >= base + need) ? 1 : 0, 1);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string l_reg, l_mem, l_bad, a64;
    int base, f, rh, r1;
    l_reg = "^12@0000a1b2: $3 <= 0000ffff#";
    l_mem = "^7@00003000: *00001234 <= deadbeef#";
    l_bad = "^1@0000000g: $1 <= 00000001#";
    a64 = "";
    for (int i = 0; i < 64; i++) a64 = {a64, "a"};

    // Reset values
    repeat (3) @(posedge clk); #1;
    check("rst_s0_ready", 32'(s0_ready), 0);
    check("rst_s1_ready", 32'(s1_ready), 0);
    check("rst_chk_char", 32'(chk_char), 0);
    check("rst_chk_reset", 32'(chk_reset), 1);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_src", 32'(res_src), 0);
    check("rst_res_type", 32'(res_type), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_counters", 32'(cnt_reg | cnt_mem | cnt_bad | cnt_abort), 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_chk_reset", 32'(chk_reset), 0);
    check("idle_busy", 32'(busy), 0);

    // Register-format line on s0
    base = res_n; f = fwd_n;
    send_line(0, l_reg);
    wait_res(base, 1);
    check("reg_pulses", res_n - base, 1);
    check("reg_src", 32'(cur_src), 0);
    check("reg_type", 32'(res_type), 1);
    check("reg_cnt", 32'(cnt_reg), 1);
    check("reg_latency", res_cyc - hash0, 2);
    check("reg_fwd_chars", fwd_n - f, l_reg.len());

    // Memory-format line on s1
    base = res_n; f = fwd_n;
    send_line(1, l_mem);
    wait_res(base, 1);
    check("mem_pulses", res_n - base, 1);
    check("mem_src", 32'(cur_src), 1);
    check("mem_type", 32'(res_type), 2);
    check("mem_cnt", 32'(cnt_mem), 1);
    check("mem_latency", res_cyc - hash1, 2);
    check("mem_fwd_chars", fwd_n - f, l_mem.len());

    // Simultaneous requests after an s1 line: s0 first
    base = res_n;
    fork
      send_line(0, l_reg);
      send_line(1, l_mem);
    join
    wait_res(base, 2);
    check("rr1_pulses", res_n - base, 2);
    check("rr1_first", 32'(prev_src), 0);
    check("rr1_second", 32'(cur_src), 1);
    check("rr1_cnt_reg", 32'(cnt_reg), 2);
    check("rr1_cnt_mem", 32'(cnt_mem), 2);

    // Bad line on s0; s1 never sees ready
    base = res_n; r1 = s1_rdy_n;
    send_line(0, l_bad);
    wait_res(base, 1);
    check("bad_type", 32'(res_type), 0);
    check("bad_src", 32'(cur_src), 0);
    check("bad_cnt", 32'(cnt_bad), 1);
    check("bad_s1_ready", s1_rdy_n - r1, 0);

    // Simultaneous requests after an s0 line: s1 first
    base = res_n;
    fork
      send_line(0, l_reg);
      send_line(1, l_mem);
    join
    wait_res(base, 2);
    check("rr2_first", 32'(prev_src), 1);
    check("rr2_second", 32'(cur_src), 0);
    check("rr2_cnt_reg", 32'(cnt_reg), 3);
    check("rr2_cnt_mem", 32'(cnt_mem), 3);

    // MAX_LINE chars without '#'
    base = res_n; f = fwd_n; rh = rst_hi;
    send_line(0, a64);
    wait_res(base, 1);
    check("max_pulses", res_n - base, 1);
    check("max_type", 32'(res_type), 3);
    check("max_src", 32'(cur_src), 0);
    check("max_cnt_abort", 32'(cnt_abort), 1);
    check("max_chk_reset_cycles", rst_hi - rh, 1);
    check("max_fwd_chars", fwd_n - f, 64);
    check("max_cnt_bad", 32'(cnt_bad), 1);

    // Valid gap mid-line
    base = res_n; rh = rst_hi;
    send_line(0, "^12@00");
    wait_res(base, 1);
    check("gap_type", 32'(res_type), 3);
    check("gap_cnt_abort", 32'(cnt_abort), 2);
    check("gap_chk_reset_cycles", rst_hi - rh, 1);

    // Asynchronous reset mid-line
    s0_valid = 1'b1; s0_char = 8'h5e;
    repeat (3) @(posedge clk); #1;
    check("mid_busy_before", 32'(busy), 1);
    base = res_n;
    #2 reset = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_s0_ready", 32'(s0_ready), 0);
    check("mid_chk_reset", 32'(chk_reset), 1);
    check("mid_chk_char", 32'(chk_char), 0);
    check("mid_counters", 32'(cnt_reg | cnt_mem | cnt_bad | cnt_abort), 0);
    s0_valid = 1'b0; s0_char = 8'h00;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("mid_no_result", res_n - base, 0);
    base = res_n;
    send_line(0, l_reg);
    wait_res(base, 1);
    check("post_type", 32'(res_type), 1);
    check("post_src", 32'(cur_src), 0);
    check("post_cnt_reg", 32'(cnt_reg), 1);
    check("post_cnt_abort", 32'(cnt_abort), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
